lector_fifo_salida: RTL and testbench
=====================================

Name: lector_fifo_salida

Overview:
- Drain-side consumer for the transaction layer's four output FIFOs; acts as the reader at the far end of the FIFO-out pop interface.
- Pops the non-empty output FIFOs in round-robin order and merges their words onto one valid/ready stream.
- Keeps a per-FIFO count of delivered words, readable through a req/idx counter interface.
- Sits between the FIFO-out bank and the downstream consumer or link.

Parameters:
- FIFO_WORD_SIZE, 10, word width; bits [FIFO_WORD_SIZE-1:FIFO_WORD_SIZE-2] hold the destination index.
- CNT_WIDTH, 5, width of each per-FIFO delivered-word counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- enable  input  1  allows new pops while 1.
- fifo_empty  input  4  empty flag of FIFO out 0..3 (bit n = FIFO n).
- data_out0..data_out3  input  FIFO_WORD_SIZE each  read data of FIFO out n; valid the cycle after pop.
- pop_FIFO_out0..pop_FIFO_out3  output  1 each  registered pop strobes.
- word_out  output  FIFO_WORD_SIZE  merged word.
- word_valid  output  1  word_out valid.
- word_ready  input  1  downstream accepts the word.
- word_src  output  2  index of the FIFO that word_out came from.
- req  input  1  counter read request.
- idx  input  2  counter select.
- cnt_data  output  CNT_WIDTH  counter value.
- cnt_valid  output  1  cnt_data valid.
- dest_error  output  1  sticky destination-mismatch flag.

Behaviour:
- Reset: asynchronous on reset_L=0, regardless of state.
  - All outputs go to 0.
  - FSM goes to IDLE and all counters clear.
  - last_grant is set to 3, so the first grant goes to FIFO 0.
  - A word in flight is discarded.
- FSM states: IDLE, POP, CAPT, SEND.
- IDLE:
  - Nothing happens if enable=0 or fifo_empty=4'b1111.
  - Otherwise grant = first n with fifo_empty[n]=0, searching from (last_grant+1) mod 4 and wrapping.
  - Register pop_FIFO_out[grant]=1, set last_grant=grant, go to POP.
- POP: the pop strobe is high for exactly this one cycle. Next state is CAPT.
- CAPT:
  - pops are 0.
  - Latch data_out[grant] into word_out and grant into word_src.
  - Set word_valid=1, go to SEND.
- SEND:
  - While word_ready=0: hold word_valid, word_out and word_src stable; issue no pops.
  - On word_valid&&word_ready at a posedge:
    - word_valid goes to 0.
    - count[word_src] increments, saturating at 2^CNT_WIDTH-1.
    - Go to IDLE.
- Throughput and latency:
  - At most one pop per 4 cycles.
  - Latency from the pop cycle to word_valid is 2 cycles.
  - Never more than one pop per cycle and never more than one word outstanding.
- A FIFO's empty flag is sampled only in IDLE; a FIFO going empty after grant does not abort the transfer.
- enable dropping mid-transfer: the current word completes through SEND, then the block stays in IDLE.
- Counter read:
  - On a posedge with req=1: cnt_data <= count[idx], cnt_valid <= 1.
  - With req=0: cnt_valid <= 0 and cnt_data holds its value.
  - Reads do not clear counters.
  - A read and an increment of the same counter in the same cycle return the pre-increment value.
- Counters never wrap.

Optional Feature:
- LECTOR_DEST_CHECK_EN defined:
  - In CAPT, if the latched word's top 2 bits differ from grant, dest_error <= 1.
  - The flag is sticky until reset; the word is still delivered.
- Not defined: dest_error is tied to 0 and no compare logic is built.

Test Plan:
- Reset: assert reset_L=0 mid-SEND -> word_valid, pops, cnt_valid, dest_error are 0 immediately; after release, the first grant goes to FIFO 0.
- Single word: fifo_empty=4'b1110, FIFO 0 returns 10'h0A6, word_ready=1 -> pop_FIFO_out0 high 1 cycle; word_out=10'h0A6, word_src=0, word_valid 2 cycles after the pop; then req=1, idx=0 gives cnt_data=1.
- Round-robin: all FIFOs non-empty for 8 words, word_ready=1 -> pop order 0,1,2,3,0,1,2,3; counters read 2,2,2,2.
- Backpressure: word_ready=0 for 5 cycles in SEND -> word_out and word_valid stable, no pops; on ready=1, exactly one handshake occurs.
- Saturation and skip: only FIFO 3 non-empty for 40 words -> no pops to 0..2; idx=3 reads 31.
- LECTOR_DEST_CHECK_EN: FIFO 1 returns 10'h0A6 -> word delivered, dest_error=1 and held; returns 0 only after reset; with the macro undefined it stays 0.

Source files
------------

// File: rtl/lector_fifo_salida_if.sv
// ----------------------------------------------------------------------------
// lector_fifo_salida_if
//   Bundles the signals between the FIFO-out bank, the output FIFO reader and
//   the downstream consumer.
//
//   FIFO-out pop side:
//     fifo_empty[3:0]     empty flag of FIFO out n (bit n)
//     data_out0..3        read data of FIFO out n, valid the cycle after pop
//     pop_FIFO_out0..3    registered pop strobes
//   Merged stream side:
//     word_out/word_src   merged word and the FIFO it came from
//     word_valid          word_out valid
//     word_ready          downstream accepts the word
//   Counter read side:
//     req/idx             counter read request and counter select
//     cnt_data/cnt_valid  counter value and its valid flag
//   Misc:
//     enable              allows new pops
//     dest_error          sticky destination-mismatch flag
//
//   Modports:
//     master  the reader block (drives pops, stream and counter outputs)
//     slave   the environment (FIFO bank, consumer, counter reader)
// ----------------------------------------------------------------------------
interface lector_fifo_salida_if #(
    parameter int FIFO_WORD_SIZE = 10,
    parameter int CNT_WIDTH      = 5
);
    logic                      enable;
    logic [3:0]                fifo_empty;
    logic [FIFO_WORD_SIZE-1:0] data_out0;
    logic [FIFO_WORD_SIZE-1:0] data_out1;
    logic [FIFO_WORD_SIZE-1:0] data_out2;
    logic [FIFO_WORD_SIZE-1:0] data_out3;
    logic                      pop_FIFO_out0;
    logic                      pop_FIFO_out1;
    logic                      pop_FIFO_out2;
    logic                      pop_FIFO_out3;
    logic [FIFO_WORD_SIZE-1:0] word_out;
    logic                      word_valid;
    logic                      word_ready;
    logic [1:0]                word_src;
    logic                      req;
    logic [1:0]                idx;
    logic [CNT_WIDTH-1:0]      cnt_data;
    logic                      cnt_valid;
    logic                      dest_error;

    modport master (
        input  enable, fifo_empty,
        input  data_out0, data_out1, data_out2, data_out3,
        input  word_ready, req, idx,
        output pop_FIFO_out0, pop_FIFO_out1, pop_FIFO_out2, pop_FIFO_out3,
        output word_out, word_valid, word_src,
        output cnt_data, cnt_valid, dest_error
    );

    modport slave (
        output enable, fifo_empty,
        output data_out0, data_out1, data_out2, data_out3,
        output word_ready, req, idx,
        input  pop_FIFO_out0, pop_FIFO_out1, pop_FIFO_out2, pop_FIFO_out3,
        input  word_out, word_valid, word_src,
        input  cnt_data, cnt_valid, dest_error
    );
endinterface

// File: rtl/lector_fifo_salida.sv
// ----------------------------------------------------------------------------
// lector_fifo_salida
//   Drain-side reader for the four output FIFOs of the transaction layer.
//   Non-empty FIFOs are popped in round-robin order, one word at a time, and
//   the words are merged onto a single valid/ready stream tagged with their
//   source index. A saturating per-FIFO count of delivered words can be read
//   through the req/idx counter port.
//
//   Transfer sequence (one word outstanding at most):
//     IDLE -> POP (pop strobe high) -> CAPT (FIFO data valid, latched)
//          -> SEND (word_valid until word_ready) -> IDLE
//
//   Ports:
//     clk      single clock, all state on posedge
//     reset_L  asynchronous active-low reset
//     bus      lector_fifo_salida_if.master (pop, stream and counter signals)
//
//   Build option:
//     LECTOR_DEST_CHECK_EN  when defined, the destination field (top two
//                           bits) of each captured word is compared with the
//                           FIFO it came from; a mismatch sets the sticky
//                           dest_error flag. When undefined dest_error is 0.
// ----------------------------------------------------------------------------
module lector_fifo_salida #(
    parameter int FIFO_WORD_SIZE = 10,
    parameter int CNT_WIDTH      = 5
) (
    input  logic                 clk,
    input  logic                 reset_L,
    lector_fifo_salida_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2,
        SEND = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Saturating increment: counters stick at their maximum.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Round-robin pick: first requester after 'last', wrapping around so that
    // 'last' itself is considered only after the other three.
    function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] last);
        logic [1:0] cand;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + k[1:0];
            if (!found && pend[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    state_t                    state_q;
    logic [1:0]                last_grant_q;
    logic [1:0]                grant_q;
    logic [3:0]                pop_q;
    logic [FIFO_WORD_SIZE-1:0] word_q;
    logic [1:0]                src_q;
    logic                      valid_q;
    logic [CNT_WIDTH-1:0]      cnt_q [0:3];
    logic [CNT_WIDTH-1:0]      cnt_data_q;
    logic                      cnt_valid_q;

    logic [1:0]                grant_d;
    logic [FIFO_WORD_SIZE-1:0] data_d;
    logic                      any_pend;

    // Arbitration and read-data selection
    always_comb begin
        grant_d  = rr_pick(~bus.fifo_empty, last_grant_q);
        any_pend = (bus.fifo_empty != 4'b1111);
        case (grant_q)
            2'd0:    data_d = bus.data_out0;
            2'd1:    data_d = bus.data_out1;
            2'd2:    data_d = bus.data_out2;
            default: data_d = bus.data_out3;
        endcase
    end

    // Transfer FSM, pop strobes, output word and delivered-word counters
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= IDLE;
            last_grant_q <= 2'd3;
            grant_q      <= 2'd0;
            pop_q        <= 4'b0000;
            word_q       <= '0;
            src_q        <= 2'd0;
            valid_q      <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // Empty flags only matter here; once granted, the
                    // transfer runs to completion.
                    if (bus.enable && any_pend) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        pop_q        <= 4'b0001 << grant_d;
                        state_q      <= POP;
                    end
                end
                POP: begin
                    pop_q   <= 4'b0000;
                    state_q <= CAPT;
                end
                CAPT: begin
                    word_q  <= data_d;
                    src_q   <= grant_q;
                    valid_q <= 1'b1;
                    state_q <= SEND;
                end
                SEND: begin
                    if (bus.word_ready) begin
                        valid_q      <= 1'b0;
                        cnt_q[src_q] <= sat_inc(cnt_q[src_q]);
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Counter read port; a same-cycle increment is seen on the next read.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_data_q  <= '0;
            cnt_valid_q <= 1'b0;
        end else begin
            cnt_valid_q <= bus.req;
            if (bus.req) begin
                cnt_data_q <= cnt_q[bus.idx];
            end
        end
    end

`ifdef LECTOR_DEST_CHECK_EN
    logic dest_err_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            dest_err_q <= 1'b0;
        end else if (state_q == CAPT &&
                     data_d[FIFO_WORD_SIZE-1 -: 2] != grant_q) begin
            dest_err_q <= 1'b1;
        end
    end

    assign bus.dest_error = dest_err_q;
`else
    assign bus.dest_error = 1'b0;
`endif

    assign bus.pop_FIFO_out0 = pop_q[0];
    assign bus.pop_FIFO_out1 = pop_q[1];
    assign bus.pop_FIFO_out2 = pop_q[2];
    assign bus.pop_FIFO_out3 = pop_q[3];
    assign bus.word_out      = word_q;
    assign bus.word_src      = src_q;
    assign bus.word_valid    = valid_q;
    assign bus.cnt_data      = cnt_data_q;
    assign bus.cnt_valid     = cnt_valid_q;

endmodule

// File: tb/tb_lector_fifo_salida.sv
// ----------------------------------------------------------------------------
// tb_lector_fifo_salida
//   Bench for lector_fifo_salida. Four behavioural FIFOs feed the reader;
//   directed sequences cover single word, round-robin order, backpressure,
//   saturation, reset in SEND and the destination check, followed by a
//   randomized run scored against a transaction-level round-robin model.
// ----------------------------------------------------------------------------
module tb_lector_fifo_salida;

    localparam int W  = 10;
    localparam int CW = 5;

`ifdef LECTOR_DEST_CHECK_EN
    localparam bit DEST_EN = 1'b1;
`else
    localparam bit DEST_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]    idx;
        logic [CW-1:0] exp_cnt;
    } rd_vec_t;

    logic clk = 1'b0;
    logic reset_L;

    lector_fifo_salida_if #(.FIFO_WORD_SIZE(W), .CNT_WIDTH(CW)) bus();

    lector_fifo_salida #(.FIFO_WORD_SIZE(W), .CNT_WIDTH(CW)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO bank: contents preloaded in mem, read data registered.
    logic [W-1:0] mem  [4][1024];
    logic [W-1:0] dout [4];
    int           loaded [4];
    int           popped [4];
    logic [3:0]   pops;

    assign pops = {bus.pop_FIFO_out3, bus.pop_FIFO_out2, bus.pop_FIFO_out1, bus.pop_FIFO_out0};
    assign bus.fifo_empty = {popped[3] >= loaded[3], popped[2] >= loaded[2],
                             popped[1] >= loaded[1], popped[0] >= loaded[0]};
    assign bus.data_out0 = dout[0];
    assign bus.data_out1 = dout[1];
    assign bus.data_out2 = dout[2];
    assign bus.data_out3 = dout[3];

    always @(posedge clk) begin
        for (int n = 0; n < 4; n++) begin
            if (pops[n] && popped[n] < loaded[n]) begin
                dout[n]   <= mem[n][popped[n]];
                popped[n] <= popped[n] + 1;
            end
        end
    end

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic         prev_valid = 1'b0;
    logic [W-1:0] prev_word = '0;
    logic [1:0]   prev_src = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock, sampled on the falling edge, with stream invariants checked.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (reset_L) begin
            chk("pop_onehot", {31'd0, $countones(pops) <= 1}, 1);
            if (bus.word_valid) chk("no_pop_busy", {28'd0, pops}, 0);
            if (prev_valid && !bus.word_ready) begin
                chk("hold_valid", {31'd0, bus.word_valid}, 1);
                chk("hold_word", {22'd0, bus.word_out}, {22'd0, prev_word});
                chk("hold_src", {30'd0, bus.word_src}, {30'd0, prev_src});
            end
        end
        prev_valid = bus.word_valid;
        prev_word  = bus.word_out;
        prev_src   = bus.word_src;
    endtask

    task automatic load_word(input int n, input logic [W-1:0] d);
        mem[n][loaded[n]] = d;
        loaded[n]++;
    endtask

    task automatic reset_pulse();
        reset_L = 1'b0;
        tick();
        tick();
        reset_L = 1'b1;
    endtask

    task automatic wait_pop(input string name, input int budget, output int which);
        int n;
        n = 0;
        which = -1;
        do begin
            tick();
            n++;
        end while (pops == 4'b0000 && n < budget);
        chk(name, {31'd0, pops != 4'b0000}, 1);
        for (int k = 0; k < 4; k++) if (pops[k]) which = k;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.word_valid && n < budget);
        chk(name, {31'd0, bus.word_valid}, 1);
    endtask

    task automatic cnt_read(input logic [1:0] i, input logic [CW-1:0] exp, input string name);
        bus.req = 1'b1;
        bus.idx = i;
        tick();
        chk({name, "_valid"}, {31'd0, bus.cnt_valid}, 1);
        chk({name, "_data"}, {27'd0, bus.cnt_data}, {27'd0, exp});
        bus.req = 1'b0;
        tick();
        chk({name, "_drop"}, {31'd0, bus.cnt_valid}, 0);
        chk({name, "_hold"}, {27'd0, bus.cnt_data}, {27'd0, exp});
    endtask

    initial begin
        rd_vec_t    rr_tab [4];
        rd_vec_t    sat_tab [2];
        int         rr_order [8];
        int         w, last_cyc, hs, base3, total, last, c;
        int         base [4];
        int         rem [4];
        int         deliv [4];
        logic       found, exp_derr;
        logic [W-1:0] d;

        for (int n = 0; n < 4; n++) rr_tab[n] = '{idx: 2'(n), exp_cnt: 5'd2};
        sat_tab[0] = '{idx: 2'd3, exp_cnt: 5'd31};
        sat_tab[1] = '{idx: 2'd0, exp_cnt: 5'd0};
        for (int i = 0; i < 8; i++) rr_order[i] = i % 4;

        reset_L        = 1'b0;
        bus.enable     = 1'b0;
        bus.word_ready = 1'b0;
        bus.req        = 1'b0;
        bus.idx        = 2'd0;
        tick();
        tick();
        chk("rst_valid", {31'd0, bus.word_valid}, 0);
        chk("rst_pops", {28'd0, pops}, 0);
        chk("rst_word", {22'd0, bus.word_out}, 0);
        chk("rst_src", {30'd0, bus.word_src}, 0);
        chk("rst_cnt_valid", {31'd0, bus.cnt_valid}, 0);
        chk("rst_cnt_data", {27'd0, bus.cnt_data}, 0);
        chk("rst_dest", {31'd0, bus.dest_error}, 0);

        // Single word from FIFO 0
        reset_L        = 1'b1;
        bus.enable     = 1'b1;
        bus.word_ready = 1'b1;
        load_word(0, 10'h0A6);
        wait_pop("p1_pop_seen", 20, w);
        chk("p1_pop_idx", {28'd0, pops}, 32'h1);
        tick();
        chk("p1_pop_width", {28'd0, pops}, 0);
        chk("p1_valid_early", {31'd0, bus.word_valid}, 0);
        tick();
        chk("p1_valid", {31'd0, bus.word_valid}, 1);
        chk("p1_word", {22'd0, bus.word_out}, 32'h0A6);
        chk("p1_src", {30'd0, bus.word_src}, 0);
        tick();
        chk("p1_valid_drop", {31'd0, bus.word_valid}, 0);
        cnt_read(2'd0, 5'd1, "p1_cnt0");

        // Round-robin across four non-empty FIFOs
        reset_pulse();
        for (int k = 0; k < 2; k++)
            for (int n = 0; n < 4; n++) load_word(n, {2'(n), 8'(8'h40 + k * 4 + n)});
        last_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            wait_pop("p2_pop_seen", 20, w);
            chk("p2_order", w, rr_order[i]);
            if (i > 0) chk("p2_spacing", cyc - last_cyc, 4);
            last_cyc = cyc;
            tick();
            tick();
            chk("p2_valid", {31'd0, bus.word_valid}, 1);
            chk("p2_word", {22'd0, bus.word_out}, {22'd0, 2'(rr_order[i]), 8'(8'h40 + (i / 4) * 4 + rr_order[i])});
            chk("p2_src", {30'd0, bus.word_src}, rr_order[i]);
        end
        tick();
        for (int i = 0; i < 4; i++) cnt_read(rr_tab[i].idx, rr_tab[i].exp_cnt, "p2_cnt");

        // Backpressure in SEND
        bus.word_ready = 1'b0;
        load_word(2, 10'h2C3);
        wait_valid("p3_valid_seen", 20);
        chk("p3_word", {22'd0, bus.word_out}, 32'h2C3);
        chk("p3_src", {30'd0, bus.word_src}, 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("p3_hold", {31'd0, bus.word_valid}, 1);
            chk("p3_no_pop", {28'd0, pops}, 0);
        end
        bus.word_ready = 1'b1;
        tick();
        chk("p3_accepted", {31'd0, bus.word_valid}, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("p3_single_hs", {31'd0, bus.word_valid | (|pops)}, 0);
        end
        cnt_read(2'd2, 5'd3, "p3_cnt2");

        // Saturation with only FIFO 3 active
        reset_pulse();
        base3 = loaded[3];
        for (int i = 0; i < 40; i++) load_word(3, {2'b11, 8'($urandom)});
        hs = 0;
        for (int i = 0; i < 600 && hs < 40; i++) begin
            tick();
            chk("p4_skip", {29'd0, pops[2:0]}, 0);
            if (bus.word_valid) begin
                chk("p4_src", {30'd0, bus.word_src}, 3);
                chk("p4_word", {22'd0, bus.word_out}, {22'd0, mem[3][base3 + hs]});
                hs++;
            end
        end
        chk("p4_count", hs, 40);
        tick();
        for (int i = 0; i < 2; i++) cnt_read(sat_tab[i].idx, sat_tab[i].exp_cnt, "p4_cnt");

        // Destination check, then reset while in SEND
        bus.word_ready = 1'b0;
        load_word(1, 10'h0A6);
        wait_valid("p5_valid_seen", 20);
        chk("p5_src", {30'd0, bus.word_src}, 1);
        chk("p5_word", {22'd0, bus.word_out}, 32'h0A6);
        tick();
        chk("p5_dest_set", {31'd0, bus.dest_error}, {31'd0, DEST_EN});
        repeat (3) tick();
        chk("p5_dest_held", {31'd0, bus.dest_error}, {31'd0, DEST_EN});
        bus.req = 1'b1;
        bus.idx = 2'd1;
        tick();
        chk("p5_cnt_valid_pre", {31'd0, bus.cnt_valid}, 1);
        reset_L = 1'b0;
        #1;
        chk("p5_rst_valid", {31'd0, bus.word_valid}, 0);
        chk("p5_rst_pops", {28'd0, pops}, 0);
        chk("p5_rst_cnt_valid", {31'd0, bus.cnt_valid}, 0);
        chk("p5_rst_dest", {31'd0, bus.dest_error}, 0);
        chk("p5_rst_word", {22'd0, bus.word_out}, 0);
        tick();
        bus.req = 1'b0;
        tick();
        reset_L = 1'b1;
        bus.word_ready = 1'b1;
        for (int n = 0; n < 4; n++) load_word(n, {2'(n), 8'h5A});
        wait_pop("p5_pop_seen", 20, w);
        chk("p5_first_grant", w, 0);
        repeat (20) tick();
        chk("p5_dest_clear", {31'd0, bus.dest_error}, 0);
        chk("p5_drained", {28'd0, bus.fifo_empty}, 32'hF);

        // Randomized traffic against a transaction-level round-robin model
        reset_pulse();
        total = 0;
        for (int n = 0; n < 4; n++) begin
            base[n]  = loaded[n];
            rem[n]   = $urandom_range(1, 40);
            deliv[n] = 0;
            total   += rem[n];
            for (int i = 0; i < rem[n]; i++) load_word(n, W'($urandom));
        end
        last = 3;
        exp_derr = 1'b0;
        hs = 0;
        for (int i = 0; i < 8000 && hs < total; i++) begin
            tick();
            bus.enable     = ($urandom_range(0, 9) != 0);
            bus.word_ready = 1'($urandom_range(0, 1));
            if (bus.word_valid && bus.word_ready) begin
                found = 1'b0;
                c = last;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && rem[(last + k) % 4] > 0) begin
                        c = (last + k) % 4;
                        found = 1'b1;
                    end
                end
                chk("p6_expected_word", {31'd0, found}, 1);
                d = mem[c][base[c] + deliv[c]];
                chk("p6_src", {30'd0, bus.word_src}, c);
                chk("p6_word", {22'd0, bus.word_out}, {22'd0, d});
                if (d[W-1 -: 2] != 2'(c)) exp_derr = 1'b1;
                deliv[c]++;
                rem[c]--;
                last = c;
                hs++;
            end
        end
        chk("p6_all_delivered", hs, total);
        bus.enable     = 1'b1;
        bus.word_ready = 1'b1;
        repeat (4) tick();
        chk("p6_dest", {31'd0, bus.dest_error}, {31'd0, DEST_EN & exp_derr});
        for (int n = 0; n < 4; n++)
            cnt_read(2'(n), (deliv[n] > 31) ? 5'd31 : 5'(deliv[n]), "p6_cnt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
